// File: rtl/debayer_line_sched_if.sv
// debayer_line_sched_if
// Bundles the scheduler's frame, line-buffer write and line-reader signals.
//   frame_start (in)  : one-cycle pulse, starts or restarts a frame
//   data_valid  (in)  : one line-buffer data word this cycle
//   rd_done     (in)  : one-cycle pulse, reader finished one line
//   wr_en/wr_addr/wr_sel (out) : line-buffer write strobe, address, buffer select
//   rd_start/rd_phase/rgb_valid (out) : reader start pulse, buffer rotation, reader enable
//   occupancy (out)   : lines written but not yet consumed (0..4)
//   frame_done (out)  : one-cycle pulse when a frame has fully drained
//   overflow (out)    : sticky, a line was dropped because all four buffers were full
//   fsm_state (out)   : debug view of the FSM, 0=IDLE 1=FILL 2=RUN 3=DRAIN
//
// Handshake rules: data_valid has no back-pressure, a word offered while the
// scheduler is not writing is simply not written. Reads are a request/complete
// pair: rd_start opens one read, the next rd_done closes it; at most one read is
// open at a time and an rd_done with no open read carries no meaning.
interface debayer_line_sched_if #(
  parameter int CNT_W = 10
);
  logic             frame_start;
  logic             data_valid;
  logic             rd_done;
  logic             wr_en;
  logic [CNT_W-1:0] wr_addr;
  logic [1:0]       wr_sel;
  logic             rd_start;
  logic [1:0]       rd_phase;
  logic             rgb_valid;
  logic [2:0]       occupancy;
  logic             frame_done;
  logic             overflow;
  logic [1:0]       fsm_state;

  modport slave (
    input  frame_start, data_valid, rd_done,
    output wr_en, wr_addr, wr_sel, rd_start, rd_phase, rgb_valid,
           occupancy, frame_done, overflow, fsm_state
  );

  modport master (
    output frame_start, data_valid, rd_done,
    input  wr_en, wr_addr, wr_sel, rd_start, rd_phase, rgb_valid,
           occupancy, frame_done, overflow, fsm_state
  );
endinterface

// File: rtl/debayer_line_sched.sv
// debayer_line_sched
// Schedules four rotating line buffers between the incoming pixel stream and
// the debayer line reader. Lines are written round-robin; reading starts once
// two lines are buffered and the frame is drained once all lines arrived.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : debayer_line_sched_if.slave (see interface for signal list)
module debayer_line_sched #(
  parameter int LINE_LENGTH = 640,
  parameter int FRAME_LINES = 480,
  parameter int CNT_W       = $clog2(LINE_LENGTH)
) (
  input logic                  clk,
  input logic                  rst,
  debayer_line_sched_if.slave  bus
);

  localparam int LC_W = $clog2(FRAME_LINES + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(LINE_LENGTH - 1);
  localparam logic [LC_W-1:0]  LINES_LAST = LC_W'(FRAME_LINES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]       wr_sel_q, wr_sel_d;
  logic [2:0]       occ_q, occ_d;
  logic [LC_W-1:0]  line_cnt_q, line_cnt_d;
  logic [1:0]       rd_phase_q, rd_phase_d;
  logic             rd_start_q, rd_start_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;

  logic writing, wr_en, line_end, line_keep, rd_busy, rd_accept;

  assign writing   = (state_q == S_FILL) || (state_q == S_RUN);
  assign wr_en     = writing && bus.data_valid;
  assign line_end  = wr_en && (wr_addr_q == ADDR_LAST);
  // A completed line is kept only if a buffer is free; otherwise it is dropped.
  assign line_keep = line_end && (occ_q != 3'd4);
  // The read is already open in the cycle rd_start is high.
  assign rd_busy   = busy_q || rd_start_q;
  assign rd_accept = bus.rd_done && rd_busy;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    wr_sel_d     = wr_sel_q;
    occ_d        = occ_q;
    line_cnt_d   = line_cnt_q;
    rd_phase_d   = rd_phase_q;
    busy_d       = busy_q;
    overflow_d   = overflow_q;
    rd_start_d   = 1'b0;
    frame_done_d = 1'b0;

    if (bus.frame_start) begin
      // Start or restart a frame; any open read is forgotten.
      state_d    = S_FILL;
      wr_addr_d  = '0;
      wr_sel_d   = 2'd0;
      occ_d      = 3'd0;
      line_cnt_d = '0;
      rd_phase_d = 2'd3;
      busy_d     = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (wr_en) wr_addr_d = line_end ? '0 : wr_addr_q + CNT_W'(1);
      if (line_end) begin
        line_cnt_d = line_cnt_q + LC_W'(1);
        if (line_keep) wr_sel_d = wr_sel_q + 2'd1;
        else           overflow_d = 1'b1;
      end
      occ_d = occ_q + {2'b00, line_keep} - {2'b00, rd_accept};
      if (rd_accept) rd_phase_d = rd_phase_q + 2'd1;
      busy_d     = rd_busy && !rd_accept;
      rd_start_d = !rd_busy &&
                   (((state_q == S_RUN)   && (occ_q >= 3'd2)) ||
                    ((state_q == S_DRAIN) && (occ_q != 3'd0)));

      case (state_q)
        S_FILL: begin
          if (line_cnt_d == LINES_LAST) state_d = S_DRAIN;
          else if (occ_d == 3'd2)       state_d = S_RUN;
        end
        S_RUN: begin
          if (line_cnt_d == LINES_LAST) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if ((occ_q == 3'd0) && !rd_busy) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      wr_sel_q     <= 2'd0;
      occ_q        <= 3'd0;
      line_cnt_q   <= '0;
      rd_phase_q   <= 2'd3;
      rd_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_sel_q     <= wr_sel_d;
      occ_q        <= occ_d;
      line_cnt_q   <= line_cnt_d;
      rd_phase_q   <= rd_phase_d;
      rd_start_q   <= rd_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_sel     = wr_sel_q;
  assign bus.rd_start   = rd_start_q;
  assign bus.rd_phase   = rd_phase_q;
  assign bus.rgb_valid  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.occupancy  = occ_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.fsm_state  = state_q;

endmodule

// File: doc/debayer_line_sched.md
DEBAYER_LINE_SCHED -- requirements
Module: debayer_line_sched

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 640: data words per line.
REQ-002 SHALL have parameter FRAME_LINES, default 480: lines per frame.
REQ-003 SHALL have parameter CNT_W, default $clog2(LINE_LENGTH): write-address width.
REQ-004 SHALL have port clk  input  1  clock. All logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port frame_start  input  1  single-cycle pulse marking the start of a frame.
REQ-007 SHALL have port data_valid  input  1  one line-buffer data word is present this cycle.
REQ-008 SHALL have port rd_done  input  1  single-cycle pulse from the line reader when a line has been fully read.
REQ-009 SHALL have port wr_en  output  1  line-buffer write strobe.
REQ-010 SHALL have port wr_addr  output  CNT_W  line-buffer write address.
REQ-011 SHALL have port wr_sel  output  2  selected line buffer, 0..3.
REQ-012 SHALL have port rd_start  output  1  single-cycle pulse that starts reading one line.
REQ-013 SHALL have port rd_phase  output  2  rotation index of the line buffers, for the reader.
REQ-014 SHALL have port rgb_valid  output  1  enable for the reader.
REQ-015 SHALL have port occupancy  output  3  lines written but not yet consumed, 0..4.
REQ-016 SHALL have port frame_done  output  1  single-cycle pulse at the end of a frame.
REQ-017 SHALL have port overflow  output  1  sticky flag: a line was dropped.

Function
REQ-018 SHALL implement an FSM with states IDLE, FILL, RUN and DRAIN.
REQ-019 In IDLE, frame_start SHALL cause a transition to FILL, clearing wr_addr, wr_sel, occupancy and the line counter, and setting rd_phase=3.
REQ-020 wr_en SHALL equal data_valid while in FILL or RUN, and SHALL be 0 in IDLE and DRAIN.
REQ-021 Each wr_en SHALL increment wr_addr; at LINE_LENGTH-1, wr_addr SHALL wrap to 0 and the cycle counts as a line completion.
REQ-022 On a line completion with occupancy<4: wr_sel SHALL increment mod 4, occupancy SHALL increment, and the line counter SHALL increment.
REQ-023 On a line completion with occupancy==4: wr_sel and occupancy SHALL NOT change, overflow SHALL set, and the line counter SHALL still increment.
REQ-024 FILL SHALL transition to RUN on the cycle in which occupancy becomes 2.
REQ-025 In RUN or DRAIN, rd_start SHALL pulse, registered, in the cycle after a cycle in which all of the following hold: occupancy>=2, or occupancy>=1 in DRAIN; no read is outstanding; rd_start was not high.
REQ-026 A read SHALL be outstanding from rd_start until rd_done.
REQ-027 rd_done SHALL decrement occupancy and increment rd_phase mod 4.
REQ-028 rd_done with no read outstanding SHALL be ignored.
REQ-029 A line completion and an rd_done in the same cycle SHALL leave occupancy unchanged; wr_sel and rd_phase SHALL each still advance.
REQ-030 When the line counter reaches FRAME_LINES, the FSM SHALL go to DRAIN; writes SHALL stop and any further data_valid SHALL be ignored.
REQ-031 In DRAIN, when occupancy==0 and no read is outstanding, the block SHALL pulse frame_done for one cycle and go to IDLE.
REQ-032 rgb_valid SHALL be 1 in RUN and DRAIN, and 0 in IDLE and FILL.
REQ-033 frame_start in FILL, RUN or DRAIN SHALL abort the current frame: re-initialise as in REQ-019, drop any outstanding read, go to FILL, and not pulse frame_done.
REQ-034 overflow SHALL clear only on rst.

Reset
REQ-035 On rst, the FSM SHALL be IDLE and wr_en, wr_addr, wr_sel, rd_start, occupancy, rgb_valid, frame_done and overflow SHALL all be 0.
REQ-036 On rst, rd_phase SHALL be 3.
REQ-037 rst asserted mid-frame SHALL take effect on the next edge, with no frame_done.

Verification (LINE_LENGTH=4, FRAME_LINES=6)
REQ-038 frame_start, then 8 consecutive data_valid -> wr_sel 0->1->2; occupancy=2; state RUN; rgb_valid=1; rd_start pulses once 1 cycle later.
REQ-039 Full frame of 24 words with rd_done returned 10 cycles after each rd_start -> 6 rd_done, rd_phase ends at (3+6) mod 4 = 1, one frame_done, overflow=0.
REQ-040 Writes with no rd_done after 4 lines -> occupancy=4; 5th line completion sets overflow, wr_sel stays 0.
REQ-041 Line completion and rd_done in the same cycle at occupancy=3 -> occupancy stays 3, wr_sel and rd_phase each +1.
REQ-042 frame_start after 3 lines written, mid-read -> occupancy=0, rd_phase=3, state FILL, no frame_done; the next 2 lines resume RUN.
REQ-043 Spurious rd_done in FILL -> ignored; occupancy and rd_phase unchanged.
